mc_fetch_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the instruction fetch/decode datapath and the downstream execute, memory and write-back stages of the RV32I-subset teaching core.
- Generates pc_write and ir_write for the PC/IR/instruction-store path, plus per-state enables for ALU, data memory and register file.
- Decodes opcode, funct3 and funct7 from the IR decoder outputs.
- Halts on an illegal opcode or an external halt request.

---
 rtl/mc_ctrl_pkg.sv | 78 +++++++
 rtl/mc_alu_dec.sv | 45 ++++
 rtl/mc_fetch_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_mc_fetch_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle fetch/execute controller.
// Contents:
//   ST_*        3-bit state encodings, also visible on state_dbg
//   OPC_*       RV32I-subset major opcodes recognised by the controller
//   op_class_t  instruction class latched in ID
//   ALU_*       alu_op codes driven during EX
//   WB_*        write-back mux select codes
//   classify()  opcode/funct3 -> op_class_t, CLS_ILL for anything unsupported
package mc_ctrl_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_IF   = 3'd1;
  localparam logic [2:0] ST_IR   = 3'd2;
  localparam logic [2:0] ST_ID   = 3'd3;
  localparam logic [2:0] ST_EX   = 3'd4;
  localparam logic [2:0] ST_MEM  = 3'd5;
  localparam logic [2:0] ST_WB   = 3'd6;
  localparam logic [2:0] ST_HALT = 3'd7;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JAL    = 3'd5,
    CLS_LUI    = 3'd6,
    CLS_ILL    = 3'd7
  } op_class_t;

  localparam int ALU_CODE_W = 4;

  localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 4'd9;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // Branches are only supported as BEQ/BNE; any other funct3 under the
  // branch opcode is treated exactly like an unknown opcode.
  function automatic op_class_t classify(input logic [6:0] opcode,
                                         input logic [2:0] funct3);
    op_class_t cls;
    case (opcode)
      OPC_R:      cls = CLS_R;
      OPC_I:      cls = CLS_I;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = (funct3 == F3_BEQ || funct3 == F3_BNE) ? CLS_BRANCH : CLS_ILL;
      OPC_JAL:    cls = CLS_JAL;
      OPC_LUI:    cls = CLS_LUI;
      default:    cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational ALU operation decoder.
// Ports:
//   cls       in   instruction class
//   funct3    in   funct3 field of the instruction
//   funct7    in   funct7 field; only bit 5 (SUB/SRA select) is meaningful
//   alu_code  out  ALU operation code, registered by the parent
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  op_class_t              cls,
  input  logic [2:0]             funct3,
  input  logic [6:0]             funct7,
  output logic [ALU_CODE_W-1:0]  alu_code
);

  logic alt;
  logic unused_funct7;

  assign alt           = funct7[5];
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Immediate-form ALU ops share the funct3 map with register form; funct7[5]
  // selects SUB only for register form, while it selects SRA for both forms.
  always_comb begin
    alu_code = ALU_ADD;
    case (cls)
      CLS_R, CLS_I: begin
        case (funct3)
          3'b000:  alu_code = (cls == CLS_R && alt) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_code = ALU_SLL;
          3'b010:  alu_code = ALU_SLT;
          3'b011:  alu_code = ALU_SLTU;
          3'b100:  alu_code = ALU_XOR;
          3'b101:  alu_code = alt ? ALU_SRA : ALU_SRL;
          3'b110:  alu_code = ALU_OR;
          3'b111:  alu_code = ALU_AND;
          default: alu_code = ALU_ADD;
        endcase
      end
      CLS_BRANCH: alu_code = ALU_SUB;
      default:    alu_code = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_fetch_ctrl.sv
// mc_fetch_ctrl: multi-cycle control FSM for the RV32I-subset teaching core.
// Sequences IF (IMEM_LAT wait states), IR capture, ID, EX, MEM and WB, and
// stops in HALT on an illegal instruction or a halt request at a boundary.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   run, halt_req          start/continue fetching; stop at next boundary
//   opcode/funct3/funct7   instruction fields from the IR decoder
//   alu_zero               ALU zero flag used for BEQ/BNE
//   pc_write, pc_src       PC update strobe and PC source (0: PC+4, 1: target)
//   ir_write               IR capture strobe
//   alu_src_b, alu_op      ALU operand-B select and operation
//   mem_read, mem_write    data-memory strobes
//   reg_write, wb_sel      register-file write strobe and write-back select
//   busy, illegal          activity flag, sticky illegal-instruction flag
//   state_dbg              current state encoding
module mc_fetch_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int IMEM_LAT = 1,
  parameter int ALU_OP_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 halt_req,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 alu_zero,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 ir_write,
  output logic                 alu_src_b,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 busy,
  output logic                 illegal,
  output logic [2:0]           state_dbg
);

  localparam logic [1:0] IF_LAST = 2'(IMEM_LAT - 1);

  logic [2:0]             state;
  logic [2:0]             next_state;
  logic [2:0]             boundary;
  logic [1:0]             if_cnt;
  op_class_t              cls_q;
  op_class_t              dec_cls;
  op_class_t              eff_cls;
  logic                   br_taken;
  logic [ALU_CODE_W-1:0]  dec_alu_code;

  logic                   pc_write_d;
  logic                   pc_src_d;
  logic                   ir_write_d;
  logic                   alu_src_b_d;
  logic [ALU_CODE_W-1:0]  alu_code_d;
  logic                   mem_read_d;
  logic                   mem_write_d;
  logic                   reg_write_d;
  logic [1:0]             wb_sel_d;

  assign dec_cls   = classify(opcode, funct3);
  assign state_dbg = state;

  // Outputs are registered from next_state, so on the ID->EX edge the class
  // register is still being loaded; use the live decode there instead.
  assign eff_cls = (state == ST_ID) ? dec_cls : cls_q;

  // The branch decision is registered as the FSM enters EX, so alu_zero is
  // taken from the operands the datapath presents at the end of ID.
  assign br_taken = (funct3 == F3_BNE) ? !alu_zero : alu_zero;

  mc_alu_dec u_alu_dec (
    .cls      (eff_cls),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_code (dec_alu_code)
  );

  // Instruction-boundary decision: halt has priority over dropping run.
  always_comb begin
    if (halt_req)
      boundary = ST_HALT;
    else if (!run)
      boundary = ST_IDLE;
    else
      boundary = ST_IF;
  end

  // Next-state logic; HALT is absorbing and only reset leaves it.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: next_state = run ? ST_IF : ST_IDLE;
      ST_IF:   next_state = (if_cnt == IF_LAST) ? ST_IR : ST_IF;
      ST_IR:   next_state = ST_ID;
      ST_ID:   next_state = (dec_cls == CLS_ILL) ? ST_HALT : ST_EX;
      ST_EX: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: next_state = ST_MEM;
          CLS_BRANCH:          next_state = boundary;
          default:             next_state = ST_WB;
        endcase
      end
      ST_MEM:  next_state = (cls_q == CLS_LOAD) ? ST_WB : boundary;
      ST_WB:   next_state = boundary;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_IDLE;
    endcase
  end

  // Moore output decode for the state being entered, so every strobe is
  // high for exactly the one cycle the FSM spends in the asserting state.
  always_comb begin
    pc_write_d  = 1'b0;
    pc_src_d    = 1'b0;
    ir_write_d  = 1'b0;
    alu_src_b_d = 1'b0;
    alu_code_d  = ALU_ADD;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    reg_write_d = 1'b0;
    wb_sel_d    = WB_ALU;
    case (next_state)
      ST_IR: begin
        ir_write_d = 1'b1;
        pc_write_d = 1'b1;
      end
      ST_EX: begin
        alu_code_d  = dec_alu_code;
        alu_src_b_d = (eff_cls inside {CLS_I, CLS_LOAD, CLS_STORE});
        if (eff_cls == CLS_BRANCH) begin
          pc_write_d = br_taken;
          pc_src_d   = br_taken;
        end
        if (eff_cls == CLS_JAL) begin
          pc_write_d = 1'b1;
          pc_src_d   = 1'b1;
        end
      end
      ST_MEM: begin
        mem_read_d  = (eff_cls == CLS_LOAD);
        mem_write_d = (eff_cls == CLS_STORE);
      end
      ST_WB: begin
        reg_write_d = 1'b1;
        case (eff_cls)
          CLS_LOAD: wb_sel_d = WB_MEM;
          CLS_JAL:  wb_sel_d = WB_PC4;
          CLS_LUI:  wb_sel_d = WB_IMM;
          default:  wb_sel_d = WB_ALU;
        endcase
      end
      default: ;
    endcase
  end

  // State, IF wait-state counter, latched class and sticky illegal flag.
  // The counter runs only while in IF and is cleared in every other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      if_cnt  <= '0;
      cls_q   <= CLS_R;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_IF)
        if_cnt <= if_cnt + 2'd1;
      else
        if_cnt <= '0;
      if (state == ST_ID) begin
        cls_q <= dec_cls;
        if (dec_cls == CLS_ILL)
          illegal <= 1'b1;
      end
    end
  end

  // Registered outputs; reset clears every strobe immediately so a reset
  // during MEM/WB cannot leak a partial write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_write  <= 1'b0;
      pc_src    <= 1'b0;
      ir_write  <= 1'b0;
      alu_src_b <= 1'b0;
      alu_op    <= ALU_OP_W'(ALU_ADD);
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      reg_write <= 1'b0;
      wb_sel    <= WB_ALU;
      busy      <= 1'b0;
    end else begin
      pc_write  <= pc_write_d;
      pc_src    <= pc_src_d;
      ir_write  <= ir_write_d;
      alu_src_b <= alu_src_b_d;
      alu_op    <= ALU_OP_W'(alu_code_d);
      mem_read  <= mem_read_d;
      mem_write <= mem_write_d;
      reg_write <= reg_write_d;
      wb_sel    <= wb_sel_d;
      busy      <= (next_state != ST_IDLE) && (next_state != ST_HALT);
    end
  end

endmodule

// File: tb/tb_mc_fetch_ctrl.sv
// tb_mc_fetch_ctrl: scoreboard bench for mc_fetch_ctrl.
// The driver issues one instruction at a time and pushes the per-cycle output
// vectors a reference model predicts; a monitor pops one vector for every
// cycle the DUT reports busy. A second instance with IMEM_LAT=2 is timed
// separately.
module tb_mc_fetch_ctrl;

  localparam int IMEM_LAT = 1;

  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4,
                 K_JAL = 5, K_LUI = 6, K_ILL = 7;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                         A_XOR = 4'd4, A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                         A_SLT = 4'd8, A_SLTU = 4'd9;

  typedef struct packed {
    logic [2:0] st;
    logic       ill;
    logic       ir_w;
    logic       pc_w;
    logic       pc_s;
    logic       src_b;
    logic [3:0] aop;
    logic       mr;
    logic       mw;
    logic       rw;
    logic [1:0] wbs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       run2;
  logic       halt_req;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alu_zero;

  logic       pc_write, pc_src, ir_write, alu_src_b;
  logic [3:0] alu_op;
  logic       mem_read, mem_write, reg_write;
  logic [1:0] wb_sel;
  logic       busy, illegal;
  logic [2:0] state_dbg;

  logic       pc_write2, pc_src2, ir_write2, alu_src_b2;
  logic [3:0] alu_op2;
  logic       mem_read2, mem_write2, reg_write2;
  logic [1:0] wb_sel2;
  logic       busy2, illegal2;
  logic [2:0] state_dbg2;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t mon_act;
  exp_t mon_exp;

  always #5 clk = ~clk;

  mc_fetch_ctrl #(.IMEM_LAT(IMEM_LAT), .ALU_OP_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .alu_zero(alu_zero),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .wb_sel(wb_sel),
    .busy(busy), .illegal(illegal), .state_dbg(state_dbg)
  );

  mc_fetch_ctrl #(.IMEM_LAT(2), .ALU_OP_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .run(run2), .halt_req(1'b0),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .alu_zero(alu_zero),
    .pc_write(pc_write2), .pc_src(pc_src2), .ir_write(ir_write2),
    .alu_src_b(alu_src_b2), .alu_op(alu_op2), .mem_read(mem_read2),
    .mem_write(mem_write2), .reg_write(reg_write2), .wb_sel(wb_sel2),
    .busy(busy2), .illegal(illegal2), .state_dbg(state_dbg2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] opcodeOf(input int kind);
    case (kind)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LOAD:  return 7'b0000011;
      K_STORE: return 7'b0100011;
      K_BR:    return 7'b1100011;
      K_JAL:   return 7'b1101111;
      K_LUI:   return 7'b0110111;
      default: return 7'b1111111;
    endcase
  endfunction

  // RV32I ALU semantics expressed as a funct3 lookup plus the two alt cases.
  function automatic logic [3:0] refAlu(input int kind, input logic [2:0] f3, input logic alt);
    logic [3:0] rv [8];
    rv = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    if (kind == K_BR) return A_SUB;
    if (kind != K_R && kind != K_I) return A_ADD;
    if (f3 == 3'd0 && kind == K_R && alt) return A_SUB;
    if (f3 == 3'd5 && alt) return A_SRA;
    return rv[f3];
  endfunction

  function automatic exp_t blankEntry(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    e.aop = A_ADD;
    return e;
  endfunction

  // Drives one instruction and queues the output vector of every busy cycle
  // it should produce; len returns that number of cycles.
  task automatic applyStimulus(input int kind, input logic [2:0] f3, input logic [6:0] f7,
                               input logic az, output int len);
    exp_t e;
    logic legal;
    logic taken;
    opcode   = opcodeOf(kind);
    funct3   = f3;
    funct7   = f7;
    alu_zero = az;
    run      = 1'b1;
    legal    = (kind != K_ILL) && !(kind == K_BR && f3 > 3'd1);
    len = 0;
    for (int i = 0; i < IMEM_LAT; i++) begin
      sb.push_back(blankEntry(3'd1));
      len++;
    end
    e = blankEntry(3'd2);
    e.ir_w = 1'b1;
    e.pc_w = 1'b1;
    sb.push_back(e);
    sb.push_back(blankEntry(3'd3));
    len += 2;
    if (!legal) return;
    e = blankEntry(3'd4);
    e.aop = refAlu(kind, f3, f7[5]);
    e.src_b = (kind == K_I || kind == K_LOAD || kind == K_STORE);
    taken = (f3 == 3'd0) ? az : !az;
    if (kind == K_BR) begin
      e.pc_w = taken;
      e.pc_s = taken;
    end
    if (kind == K_JAL) begin
      e.pc_w = 1'b1;
      e.pc_s = 1'b1;
    end
    sb.push_back(e);
    len++;
    if (kind == K_LOAD || kind == K_STORE) begin
      e = blankEntry(3'd5);
      e.mr = (kind == K_LOAD);
      e.mw = (kind == K_STORE);
      sb.push_back(e);
      len++;
    end
    if (kind == K_R || kind == K_I || kind == K_LOAD || kind == K_JAL || kind == K_LUI) begin
      e = blankEntry(3'd6);
      e.rw = 1'b1;
      e.wbs = (kind == K_LOAD) ? 2'd1 : (kind == K_JAL) ? 2'd2 : (kind == K_LUI) ? 2'd3 : 2'd0;
      sb.push_back(e);
      len++;
    end
  endtask

  task automatic runOne(input int kind, input logic [2:0] f3, input logic [6:0] f7, input logic az);
    int len;
    applyStimulus(kind, f3, f7, az, len);
    repeat (len) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_state"}, 32'(state_dbg), 32'd0);
    checkOutput({tag, "_flags"}, {30'd0, busy, illegal}, 32'd0);
    checkOutput({tag, "_strobes"},
                {25'd0, pc_write, pc_src, ir_write, alu_src_b, mem_read, mem_write, reg_write}, 32'd0);
    checkOutput({tag, "_aluop_wbsel"}, {26'd0, alu_op, wb_sel}, 32'd0);
  endtask

  task automatic quietCheck(input string tag, input int n);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      acc |= pc_write | ir_write | mem_read | mem_write | reg_write | busy;
    end
    checkOutput({tag, "_no_strobes"}, {31'd0, acc}, 32'd0);
    checkOutput({tag, "_still_halt"}, 32'(state_dbg), 32'd7);
  endtask

  task automatic pulseReset();
    rst_n    = 1'b0;
    run      = 1'b0;
    halt_req = 1'b0;
    sb.delete();
    #1;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every busy cycle must match the next queued model vector.
  always @(negedge clk) begin
    if (rst_n && busy) begin
      mon_act = {state_dbg, illegal, ir_write, pc_write, pc_src, alu_src_b, alu_op,
                 mem_read, mem_write, reg_write, wb_sel};
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL sb_underflow: got busy vector 0x%0h, expected none queued at %0t",
                 mon_act, $time);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("seq", {15'd0, mon_act}, {15'd0, mon_exp});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int len;
    int if_cycles;
    int rw_cyc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic acc;

    rst_n = 1'b1; run = 1'b0; run2 = 1'b0; halt_req = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; alu_zero = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkResetState("por");
    rst_n = 1'b1;

    $display("[TB] directed: R SUB, LOAD, BEQ taken/not taken");
    runOne(K_R, 3'b000, 7'b0100000, 1'b0);
    runOne(K_LOAD, 3'b010, 7'd0, 1'b0);
    runOne(K_BR, 3'b000, 7'd0, 1'b1);
    runOne(K_BR, 3'b000, 7'd0, 1'b0);
    runOne(K_BR, 3'b001, 7'd0, 1'b0);
    runOne(K_JAL, 3'b000, 7'd0, 1'b0);

    $display("[TB] randomized instruction stream");
    for (int n = 0; n < 40; n++) begin
      k  = int'($urandom_range(0, 6));
      f3 = 3'($urandom_range(0, 7));
      if (k == K_BR) f3 = 3'($urandom_range(0, 1));
      f7 = 7'($urandom);
      runOne(k, f3, f7, 1'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle_gap", {28'd0, busy, state_dbg}, 32'd0);
      end
    end

    $display("[TB] halt request during STORE EX");
    applyStimulus(K_STORE, 3'b010, 7'd0, 1'b0, len);
    repeat (IMEM_LAT + 3) @(posedge clk);
    @(negedge clk);
    halt_req = 1'b1;
    repeat (len - (IMEM_LAT + 3)) @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("halt_state", {27'd0, busy, illegal, state_dbg}, 32'd7);
    quietCheck("halt", 10);
    pulseReset();

    $display("[TB] reset during LOAD MEM");
    applyStimulus(K_LOAD, 3'b010, 7'd0, 1'b0, len);
    repeat (IMEM_LAT + 4) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    run = 1'b0;
    #1;
    checkResetState("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    acc = 1'b0;
    repeat (6) begin
      @(negedge clk);
      acc |= reg_write | busy;
    end
    checkOutput("post_rst_no_wb", {31'd0, acc}, 32'd0);

    $display("[TB] illegal opcode and unsupported branch");
    runOne(K_ILL, 3'b000, 7'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("ill_state", {28'd0, illegal, state_dbg}, {28'd0, 1'b1, 3'd7});
    quietCheck("ill", 20);
    pulseReset();
    checkOutput("ill_cleared", {31'd0, illegal}, 32'd0);
    runOne(K_BR, 3'b010, 7'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("badbr_state", {28'd0, illegal, state_dbg}, {28'd0, 1'b1, 3'd7});
    pulseReset();

    $display("[TB] IMEM_LAT=2 instance timing");
    opcode = 7'b0110011; funct3 = 3'd0; funct7 = 7'd0;
    run2 = 1'b1;
    if_cycles = 0;
    rw_cyc = 0;
    for (int c = 1; c <= 20 && rw_cyc == 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (state_dbg2 == 3'd1) if_cycles++;
      if (reg_write2) rw_cyc = c;
    end
    run2 = 1'b0;
    checkOutput("lat2_if_cycles", 32'(if_cycles), 32'd2);
    checkOutput("lat2_reg_write_cycle", 32'(rw_cyc), 32'd6);

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
